// File: rtl/cache_axi_arbiter_pkg.sv
// rtl/cache_axi_arbiter_pkg.sv - shared types and source indices for the cache AXI arbiter
package cache_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT_R = 3'd2,
    WAIT_W = 3'd3,
    RESP   = 3'd4
  } arb_state_t;

  typedef enum logic [2:0] {
    OWN_NONE       = 3'd0,
    OWN_ICACHE     = 3'd1,
    OWN_DCACHE_RD  = 3'd2,
    OWN_DCACHE_WR  = 3'd3,
    OWN_UNCACHE_RD = 3'd4,
    OWN_UNCACHE_WR = 3'd5
  } owner_t;

  // Request vector bit positions, listed from highest to lowest fixed priority.
  localparam int SRC_DC_WR = 0;
  localparam int SRC_UC_WR = 1;
  localparam int SRC_DC_RD = 2;
  localparam int SRC_UC_RD = 3;
  localparam int SRC_IC_RD = 4;
  localparam int NUM_SRC   = 5;

  function automatic owner_t gnt_to_owner(input logic [NUM_SRC-1:0] gnt);
    if (gnt[SRC_DC_WR]) return OWN_DCACHE_WR;
    if (gnt[SRC_UC_WR]) return OWN_UNCACHE_WR;
    if (gnt[SRC_DC_RD]) return OWN_DCACHE_RD;
    if (gnt[SRC_UC_RD]) return OWN_UNCACHE_RD;
    if (gnt[SRC_IC_RD]) return OWN_ICACHE;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// rtl/cache_axi_arbiter_if.sv - requester-side bus interfaces (line ports and uncached word port)
interface AXI_Bus_Interface #(
  parameter int DATA_W = 128
);
  logic              rd_req;
  logic              rd_rdy;
  logic [31:0]       rd_addr;
  logic              ret_valid;
  logic [DATA_W-1:0] ret_data;
  logic              wr_req;
  logic              wr_rdy;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid
  );
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid
  );
endinterface

interface AXI_UNCACHE_Interface #(
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic              rd_rdy;
  logic [31:0]       rd_addr;
  logic              ret_valid;
  logic [DATA_W-1:0] ret_data;
  logic              wr_req;
  logic              wr_rdy;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid
  );
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid
  );
endinterface

// File: rtl/cache_axi_arbiter_prio_sel.sv
// rtl/cache_axi_arbiter_prio_sel.sv - one-hot winner select; writes always win over reads
// CACHE_ARB_RR_EN: reads rotate starting after the last-granted read owner.
import cache_arb_pkg::*;

module arb_prio_sel (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [1:0]         rr_ptr_i,
  output logic [NUM_SRC-1:0] gnt_o
);

  logic [2:0] rd_req;
  logic [2:0] rd_gnt;

  // rd_req/rd_gnt bit 0 = dcache, 1 = uncache, 2 = icache
  assign rd_req = req_i[SRC_IC_RD:SRC_DC_RD];

`ifdef CACHE_ARB_RR_EN
  always_comb begin
    rd_gnt = 3'b000;
    case (rr_ptr_i)
      2'd0: begin
        if (rd_req[1])      rd_gnt = 3'b010;
        else if (rd_req[2]) rd_gnt = 3'b100;
        else if (rd_req[0]) rd_gnt = 3'b001;
      end
      2'd1: begin
        if (rd_req[2])      rd_gnt = 3'b100;
        else if (rd_req[0]) rd_gnt = 3'b001;
        else if (rd_req[1]) rd_gnt = 3'b010;
      end
      default: begin
        if (rd_req[0])      rd_gnt = 3'b001;
        else if (rd_req[1]) rd_gnt = 3'b010;
        else if (rd_req[2]) rd_gnt = 3'b100;
      end
    endcase
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr_i;

  always_comb begin
    rd_gnt = 3'b000;
    if (rd_req[0])      rd_gnt = 3'b001;
    else if (rd_req[1]) rd_gnt = 3'b010;
    else if (rd_req[2]) rd_gnt = 3'b100;
  end
`endif

  always_comb begin
    gnt_o = '0;
    if (req_i[SRC_DC_WR])      gnt_o[SRC_DC_WR] = 1'b1;
    else if (req_i[SRC_UC_WR]) gnt_o[SRC_UC_WR] = 1'b1;
    else                       gnt_o[SRC_IC_RD:SRC_DC_RD] = rd_gnt;
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// rtl/cache_axi_arbiter.sv - one-outstanding arbiter of icache/dcache/uncache onto the AXI bridge
// CACHE_ARB_RR_EN: builds the read round-robin pointer.
import cache_arb_pkg::*;

module cache_axi_arbiter #(
  parameter int LINE_W = 128,
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  AXI_Bus_Interface.slave      icache_bus,
  AXI_Bus_Interface.slave      dcache_bus,
  AXI_UNCACHE_Interface.slave  uncache_bus,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic                 bus_line,
  output logic [31:0]          bus_addr,
  output logic [LINE_W-1:0]    bus_wdata,
  input  logic                 bus_addr_ok,
  input  logic                 bus_rvalid,
  input  logic [LINE_W-1:0]    bus_rdata,
  input  logic                 bus_bvalid
);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                we_q, we_d;
  logic                line_q, line_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   data_q, data_d;

  logic [NUM_SRC-1:0]  req_vec;
  logic [NUM_SRC-1:0]  gnt;
  logic [NUM_SRC-1:0]  gnt_v;
  logic [1:0]          rr_ptr;
  logic [31:0]         sel_addr;
  logic                resp;

  logic unused_icache_wr;
  assign unused_icache_wr = ^{icache_bus.wr_req, icache_bus.wr_addr, icache_bus.wr_data};

  assign req_vec[SRC_DC_WR] = dcache_bus.wr_req;
  assign req_vec[SRC_UC_WR] = uncache_bus.wr_req;
  assign req_vec[SRC_DC_RD] = dcache_bus.rd_req;
  assign req_vec[SRC_UC_RD] = uncache_bus.rd_req;
  assign req_vec[SRC_IC_RD] = icache_bus.rd_req;

  arb_prio_sel u_prio_sel (
    .req_i    (req_vec),
    .rr_ptr_i (rr_ptr),
    .gnt_o    (gnt)
  );

  // A grant during reset would be lost, so rdy is held low while rst is high.
  assign gnt_v = (state_q == IDLE && !rst) ? gnt : '0;

  assign dcache_bus.wr_rdy  = gnt_v[SRC_DC_WR];
  assign uncache_bus.wr_rdy = gnt_v[SRC_UC_WR];
  assign dcache_bus.rd_rdy  = gnt_v[SRC_DC_RD];
  assign uncache_bus.rd_rdy = gnt_v[SRC_UC_RD];
  assign icache_bus.rd_rdy  = gnt_v[SRC_IC_RD];
  assign icache_bus.wr_rdy  = 1'b0;

`ifdef CACHE_ARB_RR_EN
  logic [1:0] rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (gnt_v[SRC_DC_RD])      rr_d = 2'd0;
    else if (gnt_v[SRC_UC_RD]) rr_d = 2'd1;
    else if (gnt_v[SRC_IC_RD]) rr_d = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 2'd2;
    else     rr_q <= rr_d;
  end

  assign rr_ptr = rr_q;
`else
  assign rr_ptr = 2'd2;
`endif

  always_comb begin
    sel_addr = '0;
    if (gnt_v[SRC_DC_WR])      sel_addr = dcache_bus.wr_addr;
    else if (gnt_v[SRC_UC_WR]) sel_addr = uncache_bus.wr_addr;
    else if (gnt_v[SRC_DC_RD]) sel_addr = dcache_bus.rd_addr;
    else if (gnt_v[SRC_UC_RD]) sel_addr = uncache_bus.rd_addr;
    else if (gnt_v[SRC_IC_RD]) sel_addr = icache_bus.rd_addr;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    line_d  = line_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (gnt_v != '0) begin
          state_d = ISSUE;
          owner_d = gnt_to_owner(gnt_v);
          we_d    = gnt_v[SRC_DC_WR] | gnt_v[SRC_UC_WR];
          line_d  = !(gnt_v[SRC_UC_WR] | gnt_v[SRC_UC_RD]);
          addr_d  = sel_addr;
          if (gnt_v[SRC_DC_WR])      wdata_d = dcache_bus.wr_data;
          else if (gnt_v[SRC_UC_WR]) wdata_d = {{(LINE_W-WORD_W){1'b0}}, uncache_bus.wr_data};
          else                       wdata_d = '0;
        end
      end
      ISSUE: begin
        if (bus_addr_ok) state_d = we_q ? WAIT_W : WAIT_R;
      end
      WAIT_R: begin
        if (bus_rvalid) begin
          state_d = RESP;
          if (owner_q == OWN_UNCACHE_RD)
            data_d = {{(LINE_W-WORD_W){1'b0}}, bus_rdata[WORD_W-1:0]};
          else
            data_d = bus_rdata;
        end
      end
      WAIT_W: begin
        if (bus_bvalid) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
      line_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  assign bus_req   = (state_q == ISSUE);
  assign bus_we    = we_q;
  assign bus_line  = line_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  assign resp = (state_q == RESP);

  assign icache_bus.ret_valid  = resp && (owner_q == OWN_ICACHE);
  assign icache_bus.ret_data   = data_q;
  assign icache_bus.wr_valid   = 1'b0;

  assign dcache_bus.ret_valid  = resp && (owner_q == OWN_DCACHE_RD);
  assign dcache_bus.wr_valid   = resp && (owner_q == OWN_DCACHE_WR);
  assign dcache_bus.ret_data   = data_q;

  assign uncache_bus.ret_valid = resp && (owner_q == OWN_UNCACHE_RD);
  assign uncache_bus.wr_valid  = resp && (owner_q == OWN_UNCACHE_WR);
  assign uncache_bus.ret_data  = data_q[WORD_W-1:0];

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb/tb_cache_axi_arbiter.sv - randomized scoreboard bench for cache_axi_arbiter
// CACHE_ARB_RR_EN selects the round-robin read model.
module tb_cache_axi_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  AXI_Bus_Interface     #(.DATA_W(128)) icache_bus ();
  AXI_Bus_Interface     #(.DATA_W(128)) dcache_bus ();
  AXI_UNCACHE_Interface #(.DATA_W(32))  uncache_bus ();

  logic         bus_req, bus_we, bus_line;
  logic [31:0]  bus_addr;
  logic [127:0] bus_wdata;
  logic         bus_addr_ok = 1'b0;
  logic         bus_rvalid  = 1'b0;
  logic [127:0] bus_rdata   = '0;
  logic         bus_bvalid  = 1'b0;

  cache_axi_arbiter #(.LINE_W(128), .WORD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .icache_bus  (icache_bus),
    .dcache_bus  (dcache_bus),
    .uncache_bus (uncache_bus),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_line    (bus_line),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .bus_bvalid  (bus_bvalid)
  );

  // Sources: 0 dcache wr, 1 uncache wr, 2 dcache rd, 3 uncache rd, 4 icache rd
  logic [4:0]   req_v = '0;
  logic [31:0]  addr_v [5];
  logic [127:0] data_v [5];

  assign dcache_bus.wr_req   = req_v[0];
  assign dcache_bus.wr_addr  = addr_v[0];
  assign dcache_bus.wr_data  = data_v[0];
  assign uncache_bus.wr_req  = req_v[1];
  assign uncache_bus.wr_addr = addr_v[1];
  assign uncache_bus.wr_data = data_v[1][31:0];
  assign dcache_bus.rd_req   = req_v[2];
  assign dcache_bus.rd_addr  = addr_v[2];
  assign uncache_bus.rd_req  = req_v[3];
  assign uncache_bus.rd_addr = addr_v[3];
  assign icache_bus.rd_req   = req_v[4];
  assign icache_bus.rd_addr  = addr_v[4];
  assign icache_bus.wr_req   = 1'b0;
  assign icache_bus.wr_addr  = '0;
  assign icache_bus.wr_data  = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           src;
    logic         we;
    logic         line;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } bus_exp_t;

  typedef struct {
    int           src;
    logic [127:0] data;
  } resp_exp_t;

  bus_exp_t  exp_bus_q [$];
  resp_exp_t exp_resp_q [$];

  bit  busy = 0;
  int  last_rd = 4;
  int  grant_cnt [5] = '{0, 0, 0, 0, 0};
  int  consumed [5]  = '{0, 0, 0, 0, 0};
  int  grant_total = 0;
  int  aborted = 0;
  int  resp_cnt = 0;
  int  accept_cnt = 0;
  int  real_pulse_cyc = -10;
  int  hold_until_cyc = 0;
  int  force_delay = -1;
  bit  use_force_data = 0;
  logic [127:0] force_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Writes first (dcache then uncache); reads by list order or rotation after last read owner.
  function automatic int pick(input logic [4:0] p, input int lr);
    if (p[0]) return 0;
    if (p[1]) return 1;
`ifdef CACHE_ARB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = 2 + ((lr - 2 + k) % 3);
      if (p[c]) return c;
    end
`else
    for (int c = 2; c < 5; c++) if (p[c]) return c;
`endif
    return -1;
  endfunction

  function automatic logic [127:0] ret_data_of(input int s);
    if (s == 4) return icache_bus.ret_data;
    if (s == 2) return dcache_bus.ret_data;
    return {96'b0, uncache_bus.ret_data};
  endfunction

  // Grant / response monitor
  initial begin
    logic [4:0] g, v, exp_g;
    int s;
    bus_exp_t be;
    resp_exp_t re;
    forever begin
      @(negedge clk);
      g = {icache_bus.rd_rdy, uncache_bus.rd_rdy, dcache_bus.rd_rdy, uncache_bus.wr_rdy, dcache_bus.wr_rdy};
      v = {icache_bus.ret_valid, uncache_bus.ret_valid, dcache_bus.ret_valid, uncache_bus.wr_valid, dcache_bus.wr_valid};
      if (rst) begin
        if (busy) aborted++;
        exp_bus_q.delete();
        exp_resp_q.delete();
        busy = 0;
        last_rd = 4;
        chk("rdy_in_reset", {123'b0, g}, '0);
      end else begin
        exp_g = '0;
        s = busy ? -1 : pick(req_v, last_rd);
        if (s >= 0) exp_g[s] = 1'b1;
        chk("grant", {122'b0, icache_bus.wr_rdy, g}, {123'b0, exp_g});
        if (s >= 0) begin
          busy = 1;
          grant_cnt[s]++;
          grant_total++;
          if (s >= 2) last_rd = s;
          be.src   = s;
          be.we    = (s <= 1);
          be.line  = (s != 1 && s != 3);
          be.addr  = addr_v[s];
          be.wdata = (s == 1) ? {96'b0, data_v[1][31:0]} : data_v[s];
          exp_bus_q.push_back(be);
        end
        if (v != '0 || icache_bus.wr_valid) begin
          chk("resp_onehot", {127'b0, ($countones(v) == 1 && !icache_bus.wr_valid)}, 128'd1);
          if (exp_resp_q.size() == 0) begin
            chk("resp_unexpected", {123'b0, v}, '0);
          end else begin
            re = exp_resp_q.pop_front();
            chk("resp_owner", {123'b0, v}, 128'(1) << re.src);
            if (re.src >= 2) chk("resp_data", ret_data_of(re.src), re.data);
            chk("resp_latency", 128'(cyc), 128'(real_pulse_cyc + 1));
            resp_cnt++;
            busy = 0;
          end
        end
      end
    end
  end

  // Bridge model: accepts requests, returns data/acks after a random delay, injects stray pulses.
  initial begin
    bit pend = 0, pend_we = 0, pend_real = 0;
    int pend_cnt = 0;
    logic [127:0] pend_data = '0;
    bus_exp_t be;
    resp_exp_t re;
    forever begin
      @(posedge clk);
      #1;
      bus_rvalid = 1'b0;
      bus_bvalid = 1'b0;
      bus_rdata  = rand128();
      if (pend) begin
        if (pend_cnt == 0) begin
          if (pend_we) bus_bvalid = 1'b1;
          else begin
            bus_rvalid = 1'b1;
            bus_rdata  = pend_data;
          end
          if (pend_real) real_pulse_cyc = cyc;
          pend = 0;
        end else begin
          pend_cnt--;
          if ($urandom_range(3) == 0) begin
            if (pend_we) bus_rvalid = 1'b1;
            else         bus_bvalid = 1'b1;
          end
        end
      end else if ($urandom_range(5) == 0) begin
        if ($urandom_range(1) == 1) bus_rvalid = 1'b1;
        else                        bus_bvalid = 1'b1;
      end
      bus_addr_ok = (cyc >= hold_until_cyc) && ($urandom_range(2) != 0);
      @(negedge clk);
      if (rst) begin
        pend_real = 0;
      end else if (bus_req) begin
        if (exp_bus_q.size() == 0) begin
          chk("bus_req_unexpected", {127'b0, bus_req}, '0);
        end else begin
          be = exp_bus_q[0];
          chk("bus_we", {127'b0, bus_we}, {127'b0, be.we});
          chk("bus_line", {127'b0, bus_line}, {127'b0, be.line});
          chk("bus_addr", {96'b0, bus_addr}, {96'b0, be.addr});
          if (be.we) chk("bus_wdata", bus_wdata, be.wdata);
          if (bus_addr_ok) begin
            void'(exp_bus_q.pop_front());
            accept_cnt++;
            pend      = 1;
            pend_real = 1;
            pend_we   = be.we;
            pend_cnt  = (force_delay >= 0) ? force_delay : int'($urandom_range(3));
            pend_data = use_force_data ? force_data : rand128();
            re.src    = be.src;
            re.data   = be.we ? '0 : ((be.src == 3) ? {96'b0, pend_data[31:0]} : pend_data);
            exp_resp_q.push_back(re);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int s = 0; s < 5; s++) begin
      if (grant_cnt[s] != consumed[s]) begin
        consumed[s] = grant_cnt[s];
        req_v[s] = 1'b0;
      end
    end
  endtask

  task automatic raise(input int s, input logic [31:0] a, input logic [127:0] d);
    req_v[s]  = 1'b1;
    addr_v[s] = a;
    data_v[s] = (s == 1) ? {96'b0, d[31:0]} : d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_v != '0 || busy || exp_resp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    step();
    chk("drain_timeout", {127'b0, (n < 300)}, 128'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {125'b0, bus_req, bus_we, bus_line}, '0);
    chk({tag, "_addr"}, {96'b0, bus_addr}, '0);
    chk({tag, "_wdata"}, bus_wdata, '0);
    chk({tag, "_rdy"}, {122'b0, icache_bus.rd_rdy, icache_bus.wr_rdy, dcache_bus.rd_rdy,
                        dcache_bus.wr_rdy, uncache_bus.rd_rdy, uncache_bus.wr_rdy}, '0);
    chk({tag, "_valid"}, {123'b0, icache_bus.ret_valid, dcache_bus.ret_valid, dcache_bus.wr_valid,
                          uncache_bus.ret_valid, uncache_bus.wr_valid}, '0);
    chk({tag, "_ret_data"}, icache_bus.ret_data, '0);
  endtask

  initial begin
    int n;
    int acc0;
    for (int s = 0; s < 5; s++) begin
      addr_v[s] = '0;
      data_v[s] = '0;
    end
    rst = 1'b1;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;

    // Single icache line refill with a known data pattern.
    use_force_data = 1;
    force_data = 128'h44444444_33333333_22222222_11111111;
    raise(4, 32'h1FC0_0000, '0);
    drain();
    use_force_data = 0;

    // Write-back ordered before the refill it makes room for.
    raise(0, 32'h0000_1000, rand128());
    raise(2, 32'h0000_2000, '0);
    drain();

    // Uncached word write.
    raise(1, 32'hBFAF_F000, 128'h0000_00FF);
    drain();

    // Bridge stalls for five cycles while another requester waits.
    hold_until_cyc = cyc + 6;
    raise(4, 32'h1FC0_0040, '0);
    step();
    raise(3, 32'hBFD0_0010, '0);
    drain();

    // Reset while waiting for read data; the late rvalid must be ignored.
    force_delay = 3;
    acc0 = accept_cnt;
    raise(4, 32'h1FC0_0080, '0);
    n = 0;
    while (accept_cnt == acc0 && n < 50) begin
      step();
      n++;
    end
    chk("rst_test_accept", {127'b0, (accept_cnt != acc0)}, 128'd1);
    rst = 1'b1;
    step();
    check_zero("midrst");
    rst = 1'b0;
    force_delay = -1;
    repeat (6) step();
    check_zero("postrst");

    // All five sources at once.
    for (int s = 0; s < 5; s++) raise(s, $urandom(), rand128());
    drain();

    // Reads held continuously.
    for (int i = 0; i < 40; i++) begin
      step();
      for (int s = 2; s < 5; s++) if (!req_v[s]) raise(s, $urandom(), '0);
    end
    drain();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step();
      if ($urandom_range(49) == 0) hold_until_cyc = cyc + int'($urandom_range(6));
      for (int s = 0; s < 5; s++) if (!req_v[s] && $urandom_range(4) == 0) raise(s, $urandom(), rand128());
    end
    drain();

    chk("bus_queue_empty", 128'(exp_bus_q.size()), '0);
    chk("resp_queue_empty", 128'(exp_resp_q.size()), '0);
    chk("resp_per_grant", 128'(resp_cnt), 128'(grant_total - aborted));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
